// File: rtl/lsu_resp_pkg.sv
// Shared definitions for the load/store responder.
// Contents: data width constants, funct3 access-size encoding, the
// responder FSM state enum and a helper that flags illegal requests.
package lsu_resp_pkg;

    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    // funct3[1:0] selects the access size, funct3[2] selects zero-extension.
    typedef enum logic [1:0] {
        SZ_BYTE   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_WORD   = 2'b10,
        SZ_DOUBLE = 2'b11
    } size_e;

    localparam int          F3_UNSIGNED_BIT = 2;
    localparam logic [2:0]  F3_LOAD_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Requests that never reach the bus: both strobes at once, the unused
    // load encoding, or a store asking for an unsigned variant.
    function automatic logic req_illegal(logic rd, logic wr, logic [2:0] f3);
        return (rd & wr) | (rd & (f3 == F3_LOAD_ILLEGAL)) | (wr & f3[F3_UNSIGNED_BIT]);
    endfunction

endpackage

// File: rtl/lsu_resp_if.sv
// Data-memory bus between the responder (master) and memory/bridge (slave).
// Signals: req_valid/req_ready request handshake, we write select,
// addr 8-byte aligned address, wdata/wstrb lane-placed store data and byte
// enables, resp_valid read data / write ack, rdata read data.
interface lsu_resp_if import lsu_resp_pkg::*; ();

    logic              req_valid;
    logic              req_ready;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              resp_valid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req_valid, we, addr, wdata, wstrb,
        input  req_ready, resp_valid, rdata
    );

    modport slave (
        input  req_valid, we, addr, wdata, wstrb,
        output req_ready, resp_valid, rdata
    );

endinterface

// File: rtl/lsu_resp_lane.sv
// lsu_lane: combinational byte-lane steering for one access.
// Inputs:  offset (addr[2:0]), funct3, wdata (store data in low bits),
//          bus_rdata (full 64-bit bus word).
// Outputs: wstrb (byte enables for the access), wdata_lane (store data moved
//          to its lanes), rdata_ext (extracted and extended load data),
//          misaligned (offset not a multiple of the access size).
module lsu_lane import lsu_resp_pkg::*; (
    input  logic [2:0]        offset,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] wdata_lane,
    output logic [DATA_W-1:0] rdata_ext,
    output logic              misaligned
);

    size_e             size;
    logic [3:0]        size_bytes;
    logic [3:0]        lane_end;
    logic [DATA_W-1:0] raw;
    logic              is_unsigned;

    assign size        = size_e'(funct3[1:0]);
    assign is_unsigned = funct3[F3_UNSIGNED_BIT];
    assign size_bytes  = 4'd1 << funct3[1:0];
    assign lane_end    = {1'b0, offset} + size_bytes;

    // A byte lane is enabled when it falls inside [offset, offset+size).
    // Lanes past byte 7 simply drop off, matching a truncated shift.
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
        assign wstrb[gi] = (4'(gi) >= {1'b0, offset}) && (4'(gi) < lane_end);
    end

    assign misaligned = (offset & 3'(size_bytes - 4'd1)) != 3'd0;
    assign wdata_lane = wdata << {offset, 3'b000};
    assign raw        = bus_rdata >> {offset, 3'b000};

    always_comb begin
        rdata_ext = raw;
        case (size)
            SZ_BYTE:   rdata_ext = is_unsigned ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            SZ_HALF:   rdata_ext = is_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            SZ_WORD:   rdata_ext = is_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            SZ_DOUBLE: rdata_ext = raw;
            default:   rdata_ext = raw;
        endcase
    end

endmodule

// File: rtl/lsu_resp.sv
// lsu_resp: data-memory responder for the RV64 core.
// Takes one load/store per request from execute, stalls the core while the
// bus access is in flight, and returns extended load data with a done pulse.
// Ports: clk, rst_n (async active-low); mem_r/mem_w/funct3/addr/wdata request
// from execute; stall/done/rdata/err back to the core; bus (master modport).
module lsu_resp import lsu_resp_pkg::*; #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    lsu_resp_if.master        bus
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_e            state_reg, state_next;
    logic [15:0]       cnt_reg, cnt_next;
    logic [DATA_W-1:0] addr_reg, wdata_reg;
    logic [2:0]        funct3_reg;
    logic              we_reg;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              err_reg, err_next;
    logic              capture;
    logic              req_any;
    logic              req_bad;

    logic [2:0]        lane_offset, lane_funct3;
    logic [STRB_W-1:0] lane_wstrb;
    logic [DATA_W-1:0] lane_wdata, lane_rdata;
    logic              lane_misaligned;

    assign req_any = mem_r | mem_w;

    // While idle the lane judges the incoming request's alignment; once the
    // request is latched it steers the latched access.
    assign lane_offset = (state_reg == ST_IDLE) ? addr[2:0] : addr_reg[2:0];
    assign lane_funct3 = (state_reg == ST_IDLE) ? funct3    : funct3_reg;

    lsu_lane u_lane (
        .offset     (lane_offset),
        .funct3     (lane_funct3),
        .wdata      (wdata_reg),
        .bus_rdata  (bus.rdata),
        .wstrb      (lane_wstrb),
        .wdata_lane (lane_wdata),
        .rdata_ext  (lane_rdata),
        .misaligned (lane_misaligned)
    );

    assign req_bad = req_illegal(mem_r, mem_w, funct3) | lane_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            funct3_reg <= '0;
            we_reg     <= 1'b0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
            if (capture) begin
                addr_reg   <= addr;
                wdata_reg  <= wdata;
                funct3_reg <= funct3;
                we_reg     <= mem_w;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        rdata_next    = rdata_reg;
        err_next      = err_reg;
        capture       = 1'b0;
        stall         = 1'b0;
        done          = 1'b0;
        bus.req_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                stall = req_any;
                if (req_any) begin
                    capture = 1'b1;
                    if (req_bad) begin
                        state_next = ST_DONE;
                        err_next   = 1'b1;
                        rdata_next = '0;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall         = 1'b1;
                bus.req_valid = 1'b1;
                if (bus.req_ready) begin
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                end
            end
            ST_WAIT: begin
                stall    = 1'b1;
                cnt_next = cnt_reg + 16'd1;
                // A response in the final waiting cycle still beats the timeout.
                if (bus.resp_valid) begin
                    state_next = ST_DONE;
                    err_next   = 1'b0;
                    rdata_next = we_reg ? '0 : lane_rdata;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = ST_DONE;
                    err_next   = 1'b1;
                    rdata_next = '0;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rdata     = rdata_reg;
    assign err       = err_reg;
    assign bus.we    = we_reg;
    assign bus.addr  = {addr_reg[DATA_W-1:3], 3'b000};
    assign bus.wdata = lane_wdata;
    assign bus.wstrb = we_reg ? lane_wstrb : '0;

endmodule
